// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over a 32-bit word memory port
module load_store_unit #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH) + 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // request channel
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_wdata_i,
  // response channel
  output logic          rsp_valid_o,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  // word-memory read port
  output logic          mem_read_en_o,
  output logic [AW-3:0] mem_read_pos_o,
  input  logic [31:0]   mem_read_data_i,
  input  logic          mem_read_valid_i,
  // word-memory write port
  output logic          mem_write_en_o,
  output logic [AW-3:0] mem_write_pos_o,
  output logic [31:0]   mem_write_data_o
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            req_err;
  logic [31:0]     load_val;
  logic [31:0]     merge_val;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Only one request can be in flight, so the unit is ready exactly when idle.
  assign req_ready_o = (state == IDLE);

  // Classify the incoming request: illegal size or an address not aligned to its size.
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = req_addr_i[0];
      SIZE_WORD: req_err = (req_addr_i[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it for loads.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    load_val = mem_read_data_i;
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_read_data_i[7:0];
      2'd1:    byte_sel = mem_read_data_i[15:8];
      2'd2:    byte_sel = mem_read_data_i[23:16];
      default: byte_sel = mem_read_data_i[31:24];
    endcase
    half_sel = addr_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
    case (size_q)
      SIZE_BYTE: load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      default:   load_val = mem_read_data_i;
    endcase
  end

  // Read-modify-write merge: overwrite only the addressed lane of the fetched word.
  always_comb begin
    merge_val = mem_read_data_i;
    if (size_q == SIZE_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) begin
        merge_val[31:16] = wdata_q[15:0];
      end else begin
        merge_val[15:0] = wdata_q[15:0];
      end
    end
  end

  // Main controller: latches the request on accept and sequences read, write and response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      we_q             <= 1'b0;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= 32'h0;
      rsp_valid_o      <= 1'b0;
      rsp_err_o        <= 1'b0;
      rsp_rdata_o      <= 32'h0;
      mem_read_en_o    <= 1'b0;
      mem_read_pos_o   <= '0;
      mem_write_en_o   <= 1'b0;
      mem_write_pos_o  <= '0;
      mem_write_data_o <= 32'h0;
    end else begin
      // strobes are single-cycle unless a state below raises them again
      mem_read_en_o  <= 1'b0;
      mem_write_en_o <= 1'b0;
      rsp_valid_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 32'h0;
            end else if (req_we_i && (req_size_i == SIZE_WORD)) begin
              // full-word stores need no read: write straight away
              state            <= WRITE;
              mem_write_en_o   <= 1'b1;
              mem_write_pos_o  <= req_addr_i[AW-1:2];
              mem_write_data_o <= req_wdata_i;
            end else begin
              state          <= RD_WAIT;
              mem_read_en_o  <= 1'b1;
              mem_read_pos_o <= req_addr_i[AW-1:2];
            end
          end
        end
        RD_WAIT: begin
          if (mem_read_valid_i) begin
            if (we_q) begin
              state            <= WRITE;
              mem_write_en_o   <= 1'b1;
              mem_write_pos_o  <= addr_q[AW-1:2];
              mem_write_data_o <= merge_val;
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= load_val;
            end
          end
        end
        WRITE: begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= 32'h0;
        end
        default: begin
          // RESP: the response strobe was this cycle; clear payload and go idle
          state       <= IDLE;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int DEPTH = 16;
  localparam int AW = 6;

  logic          clk_i;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          mem_read_en_o;
  logic [AW-3:0] mem_read_pos_o;
  logic [31:0]   mem_read_data_i;
  logic          mem_read_valid_i;
  logic          mem_write_en_o;
  logic [AW-3:0] mem_write_pos_o;
  logic [31:0]   mem_write_data_o;

  logic [31:0]   mem [DEPTH];
  logic          bd_we;
  logic [3:0]    bd_pos;
  logic [31:0]   bd_data;

  int n_checks;
  int n_fail;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_err_o        (rsp_err_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_pos_o   (mem_read_pos_o),
    .mem_read_data_i  (mem_read_data_i),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_write_en_o   (mem_write_en_o),
    .mem_write_pos_o  (mem_write_pos_o),
    .mem_write_data_o (mem_write_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Word memory with one-cycle read latency, plus a backdoor port for preloading.
  always @(posedge clk_i) begin
    mem_read_valid_i <= mem_read_en_o;
    if (mem_read_en_o) mem_read_data_i <= mem[mem_read_pos_o];
    if (mem_write_en_o) mem[mem_write_pos_o] <= mem_write_data_o;
    if (bd_we) mem[bd_pos] <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] pos, input logic [31:0] data);
    @(negedge clk_i);
    bd_we = 1'b1; bd_pos = pos; bd_data = data;
    @(negedge clk_i);
    bd_we = 1'b0;
  endtask

  // Reference: what a request should do, given the current contents of its word.
  task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                           input logic [5:0] addr, input logic [31:0] wdata, input logic [31:0] w,
                           output logic err, output logic [31:0] rdata, output logic [31:0] wword,
                           output int rd_k, output int wr_k, output int rsp_k);
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    sh = 8 * int'(addr[1:0]);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    rdata = 32'h0; wword = 32'h0; rd_k = 0; wr_k = 0; rsp_k = 1;
    if (err) begin
      rsp_k = 1;
    end else if (we && size == 2'd2) begin
      wword = wdata; wr_k = 1; rsp_k = 2;
    end else if (we) begin
      mask = (size == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
      wword = (w & ~mask) | ((wdata << sh) & mask);
      rd_k = 1; wr_k = 3; rsp_k = 4;
    end else begin
      v = w >> sh;
      if (size == 2'd0) begin
        v = v & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        v = v & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF0000;
      end
      rdata = v; rd_k = 1; rsp_k = 3;
    end
  endtask

  task automatic scramble_req();
    req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
    req_addr_i = 6'($urandom); req_wdata_i = $urandom;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata, input string tag);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
    chk({tag, "_ready_before"}, req_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    scramble_req();
  endtask

  // Observe cycles T+1 .. T+rsp_k+1 after an accept in cycle T and compare with the reference.
  task automatic monitor(input string tag, input logic [3:0] pos, input logic err,
                         input logic [31:0] rdata, input logic [31:0] wword,
                         input int rd_k, input int wr_k, input int rsp_k,
                         output logic [31:0] rdata_seen, output logic [31:0] wdata_seen);
    int rd_cnt, rd_at, wr_cnt, wr_at, rsp_cnt, rsp_at;
    logic [3:0] rd_pos, wr_pos;
    logic err_seen, both, early_ready, last_ready;
    rd_cnt = 0; rd_at = 0; wr_cnt = 0; wr_at = 0; rsp_cnt = 0; rsp_at = 0;
    rd_pos = 0; wr_pos = 0; err_seen = 0; both = 0; early_ready = 0; last_ready = 0;
    rdata_seen = 0; wdata_seen = 0;
    for (int k = 1; k <= rsp_k + 1; k++) begin
      @(negedge clk_i);
      if (mem_read_en_o) begin rd_cnt++; rd_at = k; rd_pos = mem_read_pos_o; end
      if (mem_write_en_o) begin wr_cnt++; wr_at = k; wr_pos = mem_write_pos_o; wdata_seen = mem_write_data_o; end
      if (rsp_valid_o) begin rsp_cnt++; rsp_at = k; err_seen = rsp_err_o; rdata_seen = rsp_rdata_o; end
      if (mem_read_en_o && mem_write_en_o) both = 1'b1;
      if (k <= rsp_k && req_ready_o) early_ready = 1'b1;
      if (k == rsp_k + 1) last_ready = req_ready_o;
    end
    chk({tag, "_rd_cnt"}, rd_cnt, (rd_k != 0) ? 1 : 0);
    if (rd_k != 0) begin
      chk({tag, "_rd_at"}, rd_at, rd_k);
      chk({tag, "_rd_pos"}, rd_pos, pos);
    end
    chk({tag, "_wr_cnt"}, wr_cnt, (wr_k != 0) ? 1 : 0);
    if (wr_k != 0) begin
      chk({tag, "_wr_at"}, wr_at, wr_k);
      chk({tag, "_wr_pos"}, wr_pos, pos);
      chk({tag, "_wr_data"}, wdata_seen, wword);
    end
    chk({tag, "_rsp_cnt"}, rsp_cnt, 1);
    chk({tag, "_rsp_at"}, rsp_at, rsp_k);
    chk({tag, "_rsp_err"}, err_seen, err);
    chk({tag, "_rsp_rdata"}, rdata_seen, rdata);
    chk({tag, "_en_overlap"}, both, 1'b0);
    chk({tag, "_ready_busy"}, early_ready, 1'b0);
    chk({tag, "_ready_after"}, last_ready, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [5:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata_seen, output logic [31:0] wdata_seen);
    logic e; logic [31:0] rd, ww; int rk, wk, sk;
    ref_model(we, size, uns, addr, wdata, mem[addr[5:2]], e, rd, ww, rk, wk, sk);
    issue(we, size, uns, addr, wdata, tag);
    monitor(tag, addr[5:2], e, rd, ww, rk, wk, sk, rdata_seen, wdata_seen);
  endtask

  initial begin
    logic [31:0] rs, ws;
    logic ea, eb; logic [31:0] rda, rdb, wwa, wwb; int rka, wka, ska, rkb, wkb, skb;
    int bad;
    n_checks = 0; n_fail = 0;
    bd_we = 0; bd_pos = 0; bd_data = 0;
    mem_read_valid_i = 0; mem_read_data_i = 0;
    req_valid_i = 0; scramble_req();
    rst_ni = 1'b0;
    #12;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_rd_en", mem_read_en_o, 1'b0);
    chk("rst_wr_en", mem_write_en_o, 1'b0);
    chk("rst_rd_pos", mem_read_pos_o, 4'h0);
    chk("rst_wr_pos", mem_write_pos_o, 4'h0);
    chk("rst_wr_data", mem_write_data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < DEPTH; i++) preload(4'(i), $urandom);

    // directed: word store, byte loads, half store, misaligned word load
    do_req("wstore", 1'b1, 2'd2, 1'b0, 6'h14, 32'hDEADBEEF, rs, ws);
    chk("wstore_const", ws, 32'hDEADBEEF);
    do_req("lb_s", 1'b0, 2'd0, 1'b0, 6'h17, 32'h0, rs, ws);
    chk("lb_s_const", rs, 32'hFFFFFFDE);
    do_req("lb_u", 1'b0, 2'd0, 1'b1, 6'h17, 32'h0, rs, ws);
    chk("lb_u_const", rs, 32'h000000DE);
    do_req("sh", 1'b1, 2'd1, 1'b0, 6'h16, 32'h00001234, rs, ws);
    chk("sh_const", ws, 32'h1234BEEF);
    do_req("lw_mis", 1'b0, 2'd2, 1'b0, 6'h15, 32'h0, rs, ws);
    do_req("size11", 1'b1, 2'd3, 1'b0, 6'h08, 32'h55, rs, ws);
    do_req("lh_s", 1'b0, 2'd1, 1'b0, 6'h16, 32'h0, rs, ws);

    // reset while waiting for read data drops the request
    issue(1'b1, 2'd0, 1'b0, 6'h09, 32'hA5, "rst_mid");
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ready", req_ready_o, 1'b1);
    chk("rst_mid_rd_en", mem_read_en_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (mem_write_en_o || rsp_valid_o || mem_read_en_o) bad++;
    end
    chk("rst_mid_quiet", bad, 0);
    chk("rst_mid_ready_after", req_ready_o, 1'b1);

    // back-to-back loads with req_valid held high
    ref_model(1'b0, 2'd2, 1'b0, 6'h08, 32'h0, mem[2], ea, rda, wwa, rka, wka, ska);
    ref_model(1'b0, 2'd0, 1'b1, 6'h0D, 32'h0, mem[3], eb, rdb, wwb, rkb, wkb, skb);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 6'h08; req_wdata_i = 32'h0;
    chk("b2b_ready_a", req_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    req_size_i = 2'd0; req_unsigned_i = 1'b1; req_addr_i = 6'h0D;
    monitor("b2b_a", 4'd2, ea, rda, wwa, rka, wka, ska, rs, ws);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    scramble_req();
    monitor("b2b_b", 4'd3, eb, rdb, wwb, rkb, wkb, skb, rs, ws);

    // randomized requests against the reference model
    for (int i = 0; i < 60; i++) begin
      do_req("rnd", 1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom), $urandom, rs, ws);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
